// File: rtl/w_icons_pkg.sv
// Shared constants, FSM state type and CRC5 step function for the W_ICONS command path.
package w_icons_pkg;

  localparam int unsigned CMD_W   = 4;
  localparam int unsigned LOAD_W  = 32;
  localparam int unsigned CRC_W   = 5;
  localparam int unsigned FRAME_W = 41;

  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_INIT = 5'h1F;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck,
    StDrain
  } state_e;

  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic bit_in);
    return {crc[3:0], 1'b0} ^ ((crc[4] ^ bit_in) ? CRC5_POLY : 5'h00);
  endfunction

endpackage

// File: rtl/common_crc5_serial.sv
// Serial CRC5 (x^5+x^2+1), MSB first. init reseeds and, with en, folds in bit_in on the same edge.
module common_crc5_serial
  import w_icons_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d, base;

  always_comb begin
    base  = init ? CRC5_INIT : crc_q;
    crc_d = en ? crc5_step(base, bit_in) : base;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/w_icons_cmd_crc_chk.sv
// SPI command-frame receiver with CRC5 check and first-error capture.
// Optional W_ICONS_CMD_ERR_CNT_EN adds a saturating error-event counter on err_cnt_o.
module w_icons_cmd_crc_chk #(
  parameter int unsigned CMD_W  = w_icons_pkg::CMD_W,
  parameter int unsigned LOAD_W = w_icons_pkg::LOAD_W,
  parameter int unsigned CRC_W  = w_icons_pkg::CRC_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cs_n_i,
  input  logic              sdi_i,
  input  logic              err_clr_i,
  output logic              frame_valid_o,
  output logic [CMD_W-1:0]  cmd_o,
  output logic [LOAD_W-1:0] load_o,
  output logic              error_o,
  output logic              err_frame_o,
`ifdef W_ICONS_CMD_ERR_CNT_EN
  output logic [7:0]        err_cnt_o,
`endif
  output logic [CMD_W-1:0]  chip_error_cmd_o,
  output logic [LOAD_W-1:0] chip_error_load_o,
  output logic [CRC_W-1:0]  chip_error_crc5_o
);
  import w_icons_pkg::*;

  localparam int unsigned DataW  = CMD_W + LOAD_W;
  localparam int unsigned FrameW = DataW + CRC_W;

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [FrameW-1:0]  sr_q, sr_d, cap_frame;
  logic [CRC_W-1:0]   crc_calc;
  logic               crc_init, crc_en, crc_err, short_err, err_evt;
  logic               frame_valid_q, frame_valid_d, error_q, error_d, err_frame_q, err_frame_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d, ecmd_q, ecmd_d;
  logic [LOAD_W-1:0]  load_q, load_d, eload_q, eload_d;
  logic [CRC_W-1:0]   ecrc_q, ecrc_d;
`ifdef W_ICONS_CMD_ERR_CNT_EN
  logic [7:0]         err_cnt_q, err_cnt_d;
`endif

  common_crc5_serial u_crc (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .init    (crc_init),
    .en      (crc_en),
    .bit_in  (sdi_i),
    .crc_o   (crc_calc)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_d          = sr_q;
    cap_frame     = sr_q;
    crc_init      = 1'b0;
    crc_en        = 1'b0;
    crc_err       = 1'b0;
    short_err     = 1'b0;
    frame_valid_d = 1'b0;
    cmd_d         = cmd_q;
    load_d        = load_q;
    unique case (state_q)
      StIdle: if (!cs_n_i) begin
        state_d  = StShift;
        sr_d     = {{(FrameW-1){1'b0}}, sdi_i};
        cnt_d    = 6'd1;
        crc_init = 1'b1;
        crc_en   = 1'b1;
      end
      StShift: if (cs_n_i) begin
        // Left-align the partial frame so missing bits read as zeros on the LSB side.
        short_err = 1'b1;
        state_d   = StIdle;
        cap_frame = sr_q << (6'(FrameW) - cnt_q);
      end else begin
        sr_d   = {sr_q[FrameW-2:0], sdi_i};
        cnt_d  = cnt_q + 6'd1;
        crc_en = (cnt_q < 6'(DataW));
        if (cnt_q == 6'(FrameW - 1)) state_d = StCheck;
      end
      StCheck: begin
        state_d = StDrain;
        if (crc_calc == sr_q[CRC_W-1:0]) begin
          frame_valid_d = 1'b1;
          cmd_d         = sr_q[FrameW-1 -: CMD_W];
          load_d        = sr_q[CRC_W +: LOAD_W];
        end else begin
          crc_err = 1'b1;
        end
      end
      StDrain: if (cs_n_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    err_evt     = crc_err | short_err;
    error_d     = error_q;
    err_frame_d = err_frame_q;
    ecmd_d      = ecmd_q;
    eload_d     = eload_q;
    ecrc_d      = ecrc_q;
    if (err_evt) begin
      error_d = 1'b1;
      // A clear in the same cycle re-arms capture, so the new event's fields land.
      if (!error_q || err_clr_i) begin
        err_frame_d = short_err;
        ecmd_d      = cap_frame[FrameW-1 -: CMD_W];
        eload_d     = cap_frame[CRC_W +: LOAD_W];
        ecrc_d      = cap_frame[CRC_W-1:0];
      end
    end else if (err_clr_i) begin
      error_d     = 1'b0;
      err_frame_d = 1'b0;
      ecmd_d      = '0;
      eload_d     = '0;
      ecrc_d      = '0;
    end
`ifdef W_ICONS_CMD_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
    if (err_evt) begin
      if (err_clr_i)                err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
    end else if (err_clr_i) begin
      err_cnt_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sr_q          <= '0;
      frame_valid_q <= 1'b0;
      cmd_q         <= '0;
      load_q        <= '0;
      error_q       <= 1'b0;
      err_frame_q   <= 1'b0;
      ecmd_q        <= '0;
      eload_q       <= '0;
      ecrc_q        <= '0;
`ifdef W_ICONS_CMD_ERR_CNT_EN
      err_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      frame_valid_q <= frame_valid_d;
      cmd_q         <= cmd_d;
      load_q        <= load_d;
      error_q       <= error_d;
      err_frame_q   <= err_frame_d;
      ecmd_q        <= ecmd_d;
      eload_q       <= eload_d;
      ecrc_q        <= ecrc_d;
`ifdef W_ICONS_CMD_ERR_CNT_EN
      err_cnt_q     <= err_cnt_d;
`endif
    end
  end

  assign frame_valid_o     = frame_valid_q;
  assign cmd_o             = cmd_q;
  assign load_o            = load_q;
  assign error_o           = error_q;
  assign err_frame_o       = err_frame_q;
  assign chip_error_cmd_o  = ecmd_q;
  assign chip_error_load_o = eload_q;
  assign chip_error_crc5_o = ecrc_q;
`ifdef W_ICONS_CMD_ERR_CNT_EN
  assign err_cnt_o         = err_cnt_q;
`endif

endmodule

// File: tb/tb_w_icons_cmd_crc_chk.sv
// Random and directed frame bench for w_icons_cmd_crc_chk against a frame-level reference model.
module tb_w_icons_cmd_crc_chk;

  logic        clk = 1'b0;
  logic        reset_n, cs_n, sdi, err_clr;
  logic        frame_valid, error, err_frame;
  logic [3:0]  cmd, ecmd;
  logic [31:0] load, eload;
  logic [4:0]  ecrc;
`ifdef W_ICONS_CMD_ERR_CNT_EN
  logic [7:0]  err_cnt;
  int          m_cnt = 0;
`endif

  w_icons_cmd_crc_chk dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .cs_n_i            (cs_n),
    .sdi_i             (sdi),
    .err_clr_i         (err_clr),
    .frame_valid_o     (frame_valid),
    .cmd_o             (cmd),
    .load_o            (load),
    .error_o           (error),
    .err_frame_o       (err_frame),
`ifdef W_ICONS_CMD_ERR_CNT_EN
    .err_cnt_o         (err_cnt),
`endif
    .chip_error_cmd_o  (ecmd),
    .chip_error_load_o (eload),
    .chip_error_crc5_o (ecrc)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, vcnt = 0;
  always @(negedge clk) if (frame_valid === 1'b1) vcnt++;

  // Reference state, updated once per frame
  logic        m_err, m_frame;
  logic [3:0]  m_cmd, m_ecmd;
  logic [31:0] m_load, m_eload;
  logic [4:0]  m_ecrc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_crc(input logic [35:0] d);
    logic [4:0] c = 5'h1F;
    for (int i = 35; i >= 0; i--) begin
      logic fb = c[4] ^ d[i];
      c = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return c;
  endfunction

  task automatic model_reset();
    m_err = 0; m_frame = 0; m_cmd = 0; m_load = 0; m_ecmd = 0; m_eload = 0; m_ecrc = 0;
`ifdef W_ICONS_CMD_ERR_CNT_EN
    m_cnt = 0;
`endif
  endtask

  task automatic model_clear();
    m_err = 0; m_frame = 0; m_ecmd = 0; m_eload = 0; m_ecrc = 0;
`ifdef W_ICONS_CMD_ERR_CNT_EN
    m_cnt = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".cmd"}, 64'(cmd), 64'(m_cmd));
    check_eq({tag, ".load"}, 64'(load), 64'(m_load));
    check_eq({tag, ".error"}, 64'(error), 64'(m_err));
    check_eq({tag, ".err_frame"}, 64'(err_frame), 64'(m_frame));
    check_eq({tag, ".ecmd"}, 64'(ecmd), 64'(m_ecmd));
    check_eq({tag, ".eload"}, 64'(eload), 64'(m_eload));
    check_eq({tag, ".ecrc"}, 64'(ecrc), 64'(m_ecrc));
`ifdef W_ICONS_CMD_ERR_CNT_EN
    check_eq({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_cnt));
`endif
  endtask

  // Send the first n bits of f (n = 41 is a full frame); clr pulses err_clr on the event edge.
  task automatic send(input string tag, input logic [40:0] f, input int n, input bit clr);
    int         p0 = vcnt;
    bit         good;
    logic [40:0] m, g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cs_n = 1'b0; sdi = f[40-i];
    end
    @(negedge clk); cs_n = 1'b1; sdi = 1'($urandom); err_clr = clr;
    @(negedge clk); err_clr = 1'b0;
    repeat (3) @(negedge clk);

    good = (n == 41) && (ref_crc(f[40:5]) == f[4:0]);
    if (good) begin
      m_cmd = f[40:37]; m_load = f[36:5];
      if (clr) model_clear();
    end else begin
      m = '1;
      m = m << (41 - n);
      g = f & m;
      if (!m_err || clr) begin
        m_frame = (n < 41); m_ecmd = g[40:37]; m_eload = g[36:5]; m_ecrc = g[4:0];
      end
      m_err = 1'b1;
`ifdef W_ICONS_CMD_ERR_CNT_EN
      if (clr) m_cnt = 1; else if (m_cnt < 255) m_cnt++;
`endif
    end
    check_eq({tag, ".pulses"}, 64'(vcnt - p0), good ? 64'd1 : 64'd0);
    check_all(tag);
  endtask

  task automatic clear_alone(input string tag);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    model_clear();
    check_all(tag);
  endtask

  function automatic logic [40:0] mk(input logic [3:0] c, input logic [31:0] l, input bit bad);
    logic [4:0] k = ref_crc({c, l});
    if (bad) k = k ^ 5'($urandom_range(31, 1));
    return {c, l, k};
  endfunction

  initial begin
    logic [40:0] f;
    int          p0;
    reset_n = 1'b0; cs_n = 1'b1; sdi = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("reset.valid", 64'(frame_valid), 64'd0);
    check_all("reset");

    send("good0", {4'h0, 32'h0, 5'h0C}, 41, 1'b0);
    send("bad0", {4'h0, 32'h0, 5'h0D}, 41, 1'b0);
    clear_alone("clr0");
    send("first3", mk(4'h3, 32'($urandom), 1'b1), 41, 1'b0);
    send("first5", mk(4'h5, 32'($urandom), 1'b1), 41, 1'b0);
    clear_alone("clr1");
    send("short20", mk(4'hA, 32'($urandom), 1'b0), 20, 1'b0);
    send("after_short", mk(4'h6, 32'($urandom), 1'b0), 41, 1'b0);
    send("simul", mk(4'hC, 32'($urandom), 1'b1), 41, 1'b1);
    clear_alone("clr2");

    // Reset mid-frame after bit 30 of a good frame
    f = mk(4'h9, 32'($urandom), 1'b0);
    p0 = vcnt;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk); cs_n = 1'b0; sdi = f[40-i];
    end
    @(negedge clk); reset_n = 1'b0; cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (45) @(negedge clk);
    model_reset();
    check_eq("midreset.pulses", 64'(vcnt - p0), 64'd0);
    check_all("midreset");
    send("post_reset", mk(4'h2, 32'($urandom), 1'b0), 41, 1'b0);

    for (int k = 0; k < 80; k++) begin
      int kind = $urandom_range(9, 0);
      if (kind == 0) begin
        clear_alone("rnd_clr");
      end else begin
        f = mk(4'($urandom), 32'($urandom), kind <= 3);
        send("rnd", f, (kind == 4) ? $urandom_range(40, 1) : 41, $urandom_range(7, 0) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
